// File: rtl/syn_fifo_pro.sv
// rtl/syn_fifo_pro.sv - single-clock FIFO with count, almost flags and sticky over/underflow
// Define SYN_FIFO_FWFT_EN for first-word-fall-through read data; default is registered rdata.
module syn_fifo_pro #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   winc,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rinc,
  output logic [WIDTH-1:0]       rdata,
  output logic                   wfull,
  output logic                   rempty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] data_cnt,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             w_acc;
  logic             r_acc;

  // One extra pointer bit distinguishes full from empty; the difference is the count.
  assign data_cnt     = wptr - rptr;
  assign wfull        = (data_cnt == DEPTH_C);
  assign rempty       = (data_cnt == '0);
  assign almost_full  = (data_cnt >= AFULL_C);
  assign almost_empty = (data_cnt <= AEMPTY_C);

  assign w_acc = winc && !wfull && !rst;
  assign r_acc = rinc && !rempty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) rptr <= rptr + 1'b1;
    end
  end

  // Storage is never cleared; reset only discards it by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (w_acc) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  assign rdata = mem[rptr[AW-1:0]];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (r_acc) rdata_q <= mem[rptr[AW-1:0]];
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_syn_fifo_pro.sv
// tb/tb_syn_fifo_pro.sv - randomized self-checking bench for syn_fifo_pro against a queue model
module tb_syn_fifo_pro;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int AET   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             winc = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             rinc = 1'b0;
  logic [WIDTH-1:0] rdata;
  logic             wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]       data_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [WIDTH-1:0] m_rd  = '0;

  always #5 clk = ~clk;

  syn_fifo_pro #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .wfull(wfull), .rempty(rempty), .almost_full(almost_full), .almost_empty(almost_empty),
    .data_cnt(data_cnt), .overflow(overflow), .underflow(underflow)
  );

  // Drive one cycle of requests and advance the model by the FIFO's acceptance rules.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit full, empty;
    winc = w; wdata = d; rinc = r;
    @(posedge clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (rst) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rd = '0;
    end else begin
      if (w && full)  m_ovf = 1;
      if (r && empty) m_unf = 1;
      if (r && !empty) m_rd = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    #1;
    winc = 0; rinc = 0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1;
    cycle(w, 8'hEE, r);
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset(1, 1);
    checks++; if (data_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", data_cnt); end
    checks++; if ({rempty, almost_empty, wfull, almost_full} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b exp 1100", {rempty, almost_empty, wfull, almost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {overflow, underflow}); end
`ifndef SYN_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
`endif
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1, WIDTH'(i), 0);
      checks++; if (almost_full !== (i >= AFT)) begin errors++; $display("FAIL fill_afull cnt %0d got %b exp %b", i, almost_full, (i >= AFT)); end
      checks++; if (data_cnt !== 5'(i)) begin errors++; $display("FAIL fill_cnt got %0d exp %0d", data_cnt, i); end
    end
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_wfull got %b exp 1", wfull); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow;
    cycle(1, 8'hAA, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (data_cnt !== 5'd16) begin errors++; $display("FAIL ovf_cnt got %0d exp 16", data_cnt); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYN_FIFO_FWFT_EN
      checks++; if (rdata !== WIDTH'(i)) begin errors++; $display("FAIL drain_fwft got %h exp %h", rdata, WIDTH'(i)); end
`endif
      cycle(0, 0, 1);
`ifndef SYN_FIFO_FWFT_EN
      checks++; if (rdata !== WIDTH'(i)) begin errors++; $display("FAIL drain_rdata got %h exp %h", rdata, WIDTH'(i)); end
`endif
      checks++; if (almost_empty !== (DEPTH - i <= AET)) begin errors++; $display("FAIL drain_aempty cnt %0d got %b", DEPTH - i, almost_empty); end
    end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b exp 1", rempty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_rw;
    do_reset(0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0);
    cycle(1, 8'hBB, 1);
    checks++; if (data_cnt !== 5'd15) begin errors++; $display("FAIL fullrw_cnt got %0d exp 15", data_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullrw_ovf got %b exp 1", overflow); end
`ifndef SYN_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h40) begin errors++; $display("FAIL fullrw_rdata got %h exp 40", rdata); end
`endif
  endtask

  task automatic test_underflow;
    do_reset(0, 0);
    cycle(1, 8'h55, 1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", underflow); end
    checks++; if (data_cnt !== 5'd1) begin errors++; $display("FAIL unf_cnt got %0d exp 1", data_cnt); end
`ifdef SYN_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL unf_fwft got %h exp 55", rdata); end
`else
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL unf_rdata_hold got %h exp 00", rdata); end
    cycle(0, 0, 1);
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL unf_read got %h exp 55", rdata); end
`endif
  endtask

  task automatic test_stream;
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) cycle(1, WIDTH'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
`ifdef SYN_FIFO_FWFT_EN
      checks++; if (rdata !== q[0]) begin errors++; $display("FAIL stream_fwft got %h exp %h", rdata, q[0]); end
`endif
      cycle(1, WIDTH'($urandom), 1);
      checks++; if (data_cnt !== 5'd8) begin errors++; $display("FAIL stream_cnt got %0d exp 8", data_cnt); end
`ifndef SYN_FIFO_FWFT_EN
      checks++; if (rdata !== m_rd) begin errors++; $display("FAIL stream_rdata got %h exp %h", rdata, m_rd); end
`endif
    end
  endtask

  task automatic test_midreset;
    do_reset(0, 0);
    for (int i = 0; i < 10; i++) cycle(1, WIDTH'($urandom), 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    do_reset(1, 0);
    checks++; if ({data_cnt, rempty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL mrst_state got cnt %0d rempty %b exp 0 1", data_cnt, rempty); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mrst_sticky got %b exp 00", {overflow, underflow}); end
    cycle(1, 8'h3C, 0);
`ifdef SYN_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL mrst_new got %h exp 3c", rdata); end
`else
    cycle(0, 0, 1);
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL mrst_new got %h exp 3c", rdata); end
`endif
  endtask

  task automatic test_random;
    int pw, pr;
    do_reset(0, 0);
    for (int i = 0; i < 600; i++) begin
      pw = (i % 200 < 100) ? 75 : 30;
      pr = (i % 200 < 100) ? 30 : 75;
      cycle($urandom_range(0, 99) < pw, WIDTH'($urandom), $urandom_range(0, 99) < pr);
      checks++;
      if (data_cnt !== 5'(q.size()) || wfull !== (q.size() == DEPTH) || rempty !== (q.size() == 0) ||
          almost_full !== (q.size() >= AFT) || almost_empty !== (q.size() <= AET) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL rand_status cyc %0d got cnt %0d f%b e%b af%b ae%b o%b u%b exp cnt %0d o%b u%b",
                 i, data_cnt, wfull, rempty, almost_full, almost_empty, overflow, underflow, q.size(), m_ovf, m_unf);
      end
`ifdef SYN_FIFO_FWFT_EN
      if (q.size() != 0) begin
        checks++; if (rdata !== q[0]) begin errors++; $display("FAIL rand_fwft got %h exp %h", rdata, q[0]); end
      end
`else
      checks++; if (rdata !== m_rd) begin errors++; $display("FAIL rand_rdata got %h exp %h", rdata, m_rd); end
`endif
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_full_rw();
    test_underflow();
    test_stream();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
